// File: rtl/game_pkg.sv
// Shared types for the game-state stage: top-level FSM states and BCD score digits.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAYING,
        FLASH,
        OVER,
        WON
    } game_state_e;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [3:0] bcd_score_t;

    localparam bcd_score_t SCORE_MAX = 16'h9999;

endpackage

// File: rtl/bcd_score_adder.sv
// Combinational 4-digit BCD add of a single-digit constant, saturating at 9999.
module bcd_score_adder
    import game_pkg::*;
(
    input  logic [15:0] i_score,
    input  logic [3:0]  i_addend,
    output logic [15:0] o_sum,
    output logic        o_saturated
);

    bcd_score_t w_in;
    bcd_score_t w_out;
    logic [4:0] w_digit;
    logic       w_carry;

    assign w_in = i_score;

    always_comb begin
        w_out   = '0;
        w_carry = 1'b0;
        w_digit = '0;
        for (int unsigned d = 0; d < 4; d++) begin
            w_digit = {1'b0, w_in[d]} + {4'd0, w_carry} + ((d == 0) ? {1'b0, i_addend} : 5'd0);
            if (w_digit > 5'd9) begin
                w_out[d] = 4'(w_digit - 5'd10);
                w_carry  = 1'b1;
            end else begin
                w_out[d] = w_digit[3:0];
                w_carry  = 1'b0;
            end
        end
        // Carry out of the thousands digit means the true sum exceeds 9999.
        o_saturated = w_carry;
        o_sum       = w_carry ? SCORE_MAX : w_out;
    end

endmodule

// File: rtl/hit_score_manager.sv
// Game FSM, BCD score, lives, hit tally and player-flash timing downstream of the collision controller.
module hit_score_manager
    import game_pkg::*;
#(
    parameter int unsigned SCORE_PER_HIT = 1,
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned FLASH_FRAMES  = 30,
    parameter int unsigned WIN_HITS      = 55
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        startGame,
    input  logic        alienHitPulse,
    input  logic        playerHitPulse,
    output logic [15:0] score_bcd,
    output logic [1:0]  lives,
    output logic        playing,
    output logic        playerBlink,
    output logic        gameOver,
    output logic        gameWon
);

    game_state_e r_state;
    game_state_e w_state_next;
    bcd_score_t  r_score;
    bcd_score_t  w_score_next;
    logic [1:0]  r_lives;
    logic [1:0]  w_lives_next;
    logic [7:0]  r_hits;
    logic [7:0]  w_hits_next;
    logic [7:0]  w_hits_inc;
    logic [5:0]  r_flash;
    logic [5:0]  w_flash_next;
    logic        w_win;

    logic [15:0] w_add_sum;
    logic        w_add_sat;

    logic r_playing, r_blink, r_over, r_won;
    logic w_playing_d, w_blink_d, w_over_d, w_won_d;

    bcd_score_adder u_adder (
        .i_score     (r_score),
        .i_addend    (4'(SCORE_PER_HIT)),
        .o_sum       (w_add_sum),
        .o_saturated (w_add_sat)
    );

    assign w_hits_inc = r_hits + 8'd1;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= IDLE;
            r_score   <= '0;
            r_lives   <= '0;
            r_hits    <= '0;
            r_flash   <= '0;
            r_playing <= 1'b0;
            r_blink   <= 1'b0;
            r_over    <= 1'b0;
            r_won     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_score   <= w_score_next;
            r_lives   <= w_lives_next;
            r_hits    <= w_hits_next;
            r_flash   <= w_flash_next;
            r_playing <= w_playing_d;
            r_blink   <= w_blink_d;
            r_over    <= w_over_d;
            r_won     <= w_won_d;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_score_next = r_score;
        w_lives_next = r_lives;
        w_hits_next  = r_hits;
        w_flash_next = r_flash;
        w_win        = 1'b0;
        case (r_state)
            IDLE, OVER, WON: begin
                if (startGame) begin
                    w_state_next = PLAYING;
                    w_score_next = '0;
                    w_lives_next = 2'(START_LIVES);
                    w_hits_next  = '0;
                    w_flash_next = '0;
                end
            end
            PLAYING, FLASH: begin
                // Alien hit resolves first; a winning hit swallows any same-cycle player hit.
                if (alienHitPulse) begin
                    w_score_next = w_add_sat ? SCORE_MAX : w_add_sum;
                    w_hits_next  = w_hits_inc;
                    if (w_hits_inc == 8'(WIN_HITS)) begin
                        w_state_next = WON;
                        w_flash_next = '0;
                        w_win        = 1'b1;
                    end
                end
                if (!w_win) begin
                    if (r_state == PLAYING && playerHitPulse) begin
                        if (r_lives == 2'd1) begin
                            w_lives_next = '0;
                            w_state_next = OVER;
                        end else begin
                            w_lives_next = r_lives - 2'd1;
                            w_flash_next = 6'(FLASH_FRAMES);
                            w_state_next = FLASH;
                        end
                    end else if (r_state == FLASH && startOfFrame) begin
                        if (r_flash == 6'd1) begin
                            w_flash_next = '0;
                            w_state_next = PLAYING;
                        end else begin
                            w_flash_next = r_flash - 6'd1;
                        end
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_playing_d = (w_state_next == PLAYING) || (w_state_next == FLASH);
        w_blink_d   = (w_state_next == FLASH) && w_flash_next[2];
        w_over_d    = (w_state_next == OVER);
        w_won_d     = (w_state_next == WON);
    end

    assign score_bcd   = r_score;
    assign lives       = r_lives;
    assign playing     = r_playing;
    assign playerBlink = r_blink;
    assign gameOver    = r_over;
    assign gameWon     = r_won;

endmodule

// File: tb/tb_hit_score_manager.sv
// Bench for hit_score_manager: two parameter sets against a decimal-score game model, plus adder boundary checks.
module tb_hit_score_manager;

    localparam int P_SPH   [2] = '{1, 7};
    localparam int P_LIVES [2] = '{3, 2};
    localparam int P_FLASH [2] = '{30, 5};
    localparam int P_WIN   [2] = '{55, 4};

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_FLASH = 2;
    localparam int M_OVER  = 3;
    localparam int M_WON   = 4;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startOfFrame = 1'b0, startGame = 1'b0, alienHitPulse = 1'b0, playerHitPulse = 1'b0;

    logic [15:0] a_score, b_score;
    logic [1:0]  a_lives, b_lives;
    logic        a_play, a_blink, a_over, a_won;
    logic        b_play, b_blink, b_over, b_won;

    logic [15:0] add_in, add_sum;
    logic [3:0]  add_k;
    logic        add_sat;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    int m_mode [2], m_score [2], m_lives [2], m_hits [2], m_flash [2];

    always #5 clk = ~clk;

    hit_score_manager dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
        .alienHitPulse(alienHitPulse), .playerHitPulse(playerHitPulse),
        .score_bcd(a_score), .lives(a_lives), .playing(a_play), .playerBlink(a_blink),
        .gameOver(a_over), .gameWon(a_won)
    );

    hit_score_manager #(
        .SCORE_PER_HIT(7), .START_LIVES(2), .FLASH_FRAMES(5), .WIN_HITS(4)
    ) dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
        .alienHitPulse(alienHitPulse), .playerHitPulse(playerHitPulse),
        .score_bcd(b_score), .lives(b_lives), .playing(b_play), .playerBlink(b_blink),
        .gameOver(b_over), .gameWon(b_won)
    );

    bcd_score_adder u_add (
        .i_score(add_in), .i_addend(add_k), .o_sum(add_sum), .o_saturated(add_sat)
    );

    logic [21:0] obs_a, obs_b;
    assign obs_a = {a_score, a_lives, a_play, a_blink, a_over, a_won};
    assign obs_b = {b_score, b_lives, b_play, b_blink, b_over, b_won};

    function automatic logic [15:0] to_bcd(int v);
        return 16'(((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    function automatic logic [21:0] exp_obs(int k);
        logic blink;
        blink = (m_mode[k] == M_FLASH) && ((m_flash[k] & 4) != 0);
        return {to_bcd(m_score[k]), 2'(m_lives[k]),
                1'(m_mode[k] == M_PLAY || m_mode[k] == M_FLASH), blink,
                1'(m_mode[k] == M_OVER), 1'(m_mode[k] == M_WON)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE; m_score[k] = 0; m_lives[k] = 0; m_hits[k] = 0; m_flash[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit sg, input bit sof, input bit ah, input bit ph);
        bit won;
        won = 1'b0;
        if (m_mode[k] == M_IDLE || m_mode[k] == M_OVER || m_mode[k] == M_WON) begin
            if (sg) begin
                m_mode[k] = M_PLAY; m_score[k] = 0; m_lives[k] = P_LIVES[k];
                m_hits[k] = 0; m_flash[k] = 0;
            end
        end else begin
            if (ah) begin
                m_score[k] = (m_score[k] + P_SPH[k] > 9999) ? 9999 : m_score[k] + P_SPH[k];
                m_hits[k]++;
                if (m_hits[k] == P_WIN[k]) begin
                    m_mode[k] = M_WON; m_flash[k] = 0; won = 1'b1;
                end
            end
            if (!won) begin
                if (m_mode[k] == M_PLAY && ph) begin
                    m_lives[k]--;
                    if (m_lives[k] == 0) m_mode[k] = M_OVER;
                    else begin m_mode[k] = M_FLASH; m_flash[k] = P_FLASH[k]; end
                end else if (m_mode[k] == M_FLASH && sof) begin
                    m_flash[k]--;
                    if (m_flash[k] == 0) m_mode[k] = M_PLAY;
                end
            end
        end
    endtask

    task automatic step(input bit sg, input bit sof, input bit ah, input bit ph);
        startGame = sg; startOfFrame = sof; alienHitPulse = ah; playerHitPulse = ph;
        @(posedge clk);
        if (resetN) for (int k = 0; k < 2; k++) model_step(k, sg, sof, ah, ph);
        #1;
        startGame = 0; startOfFrame = 0; alienHitPulse = 0; playerHitPulse = 0;
    endtask

    task automatic frame(input bit ah, input bit ph);
        step(0, 1, 0, 0);
        step(0, 0, ah, ph);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic add_check(input int v, input int k);
        int s;
        add_in = to_bcd(v);
        add_k = 4'(k);
        #1;
        s = (v + k > 9999) ? 9999 : v + k;
        check("bcd_adder", {15'd0, add_sat, add_sum}, {15'd0, 1'(v + k > 9999), to_bcd(s)});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("dut_a", 32'(obs_a), 32'(exp_obs(0)));
            check("dut_b", 32'(obs_b), 32'(exp_obs(1)));
        end
    end

    initial begin
        model_reset();

        // Adder boundaries, with literal expectations pinning the decimal model.
        add_in = 16'h0095; add_k = 4'd7; #1;
        check("add_0095_p7", {15'd0, add_sat, add_sum}, {15'd0, 1'b0, 16'h0102});
        add_in = 16'h9998; add_k = 4'd1; #1;
        check("add_9998_p1", {15'd0, add_sat, add_sum}, {15'd0, 1'b0, 16'h9999});
        add_in = 16'h9999; add_k = 4'd1; #1;
        check("add_9999_p1", {15'd0, add_sat, add_sum}, {15'd0, 1'b1, 16'h9999});
        add_check(95, 7);
        add_check(9998, 1);
        add_check(9999, 9);
        add_check(9995, 7);
        add_check(999, 1);
        for (int i = 0; i < 60; i++) add_check(int'($urandom_range(0, 9999)), int'($urandom_range(1, 9)));

        repeat (2) @(posedge clk);
        #1;
        check("reset_a", 32'(obs_a), 32'd0);
        check("reset_b", 32'(obs_b), 32'd0);
        chk_en = 1'b1;
        resetN = 1'b1;

        step(1, 0, 0, 0);
        check("start_a", {13'd0, a_score, a_lives, a_play}, {13'd0, 16'h0000, 2'd3, 1'b1});

        repeat (12) frame(1, 0);
        check("score12_a", 32'(a_score), 32'h0012);
        check("won_b", 32'(obs_b), 32'({16'h0028, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1}));

        frame(0, 1);
        check("hit1_a", {29'd0, a_lives, a_play}, {29'd0, 2'd2, 1'b1});
        frame(0, 1);
        check("flash_ignore_a", 32'(a_lives), 32'd2);
        repeat (28) frame(0, 0);
        step(0, 0, 0, 1);
        check("flash_last_a", 32'(a_lives), 32'd2);
        frame(0, 0);
        frame(0, 1);
        check("hit2_a", 32'(a_lives), 32'd1);
        repeat (30) frame(0, 0);
        frame(0, 1);
        check("over_a", {28'd0, a_lives, a_play, a_over}, {28'd0, 2'd0, 1'b0, 1'b1});
        frame(1, 0);
        check("over_frozen_a", 32'(a_score), 32'h0012);

        step(1, 0, 0, 0);
        check("restart_a", {13'd0, a_score, a_lives, a_play}, {13'd0, 16'h0000, 2'd3, 1'b1});

        repeat (3) frame(1, 0);
        frame(1, 1);
        check("win_coincide_b", {13'd0, b_score, b_lives, b_won}, {13'd0, 16'h0028, 2'd2, 1'b1});
        repeat (38) frame(1, 0);
        frame(0, 1);
        check("flash42_a", {13'd0, a_score, a_lives, a_play}, {13'd0, 16'h0042, 2'd1, 1'b1});
        step(0, 1, 0, 0);
        #2;
        resetN = 1'b0;
        model_reset();
        #1;
        check("async_reset_a", 32'(obs_a), 32'd0);
        check("async_reset_b", 32'(obs_b), 32'd0);
        step(1, 1, 1, 1);
        resetN = 1'b1;
        step(0, 0, 1, 1);

        for (int f = 0; f < 320; f++) begin
            int len, c_sg, c_ah, c_ph;
            bit do_sg, do_ah, do_ph;
            if ($urandom_range(0, 149) == 0) begin
                resetN = 1'b0;
                model_reset();
                step(0, 0, 0, 0);
                resetN = 1'b1;
            end
            len = int'($urandom_range(3, 6));
            do_sg = ($urandom_range(0, 9) == 0);
            do_ah = ($urandom_range(0, 1) == 1);
            do_ph = ($urandom_range(0, 5) == 0);
            c_sg = int'($urandom_range(0, 5));
            c_ah = int'($urandom_range(0, 5));
            c_ph = int'($urandom_range(0, 5));
            for (int c = 0; c < len; c++)
                step(do_sg && c == c_sg, c == 0, do_ah && c == c_ah, do_ph && c == c_ph);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/hit_score_manager.md
# hit_score_manager

Game-state and scoring stage directly downstream of the collision controller. Consumes the controller's one-per-frame hit pulses (alien hit, player hit) plus startOfFrame. Maintains a saturating 4-digit BCD score, a lives counter, a hit tally and the top-level game FSM. Drives the score display, the player-blink overlay and the game-over/win screens.

## Interface
Parameters:
- SCORE_PER_HIT, 1: BCD points added per alien hit; legal 1..9.
- START_LIVES, 3: lives loaded on game start; legal 1..3.
- FLASH_FRAMES, 30: frames of player invulnerability/blink after a player hit; legal 1..63.
- WIN_HITS, 55: alien hits that end the game as won; legal 1..255.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse per frame.
- startGame  in  1  one-cycle pulse from the debounced start key.
- alienHitPulse  in  1  one-cycle pulse, at most one per frame.
- playerHitPulse  in  1  one-cycle pulse, at most one per frame.
- score_bcd  out  16  four BCD digits; [15:12] thousands, [3:0] units.
- lives  out  2  remaining lives.
- playing  out  1  high in PLAYING and FLASH.
- playerBlink  out  1  high in FLASH while frame counter bit 2 = 1.
- gameOver  out  1  high in OVER.
- gameWon  out  1  high in WON.

## Operation
- States: IDLE, PLAYING, FLASH, OVER, WON.
- IDLE: startGame -> PLAYING. Load score=0, lives=START_LIVES, hits=0.
- OVER / WON: outputs frozen. startGame -> PLAYING with the same load as from IDLE.
- PLAYING, alienHitPulse: score += SCORE_PER_HIT in BCD (per-digit carry), saturating at 9999. hits += 1.
  - If hits+1 == WIN_HITS -> WON.
- PLAYING, playerHitPulse:
  - If lives == 1: lives=0 -> OVER.
  - Else: lives -= 1, load flash counter = FLASH_FRAMES -> FLASH.
- FLASH: alien hits scored as in PLAYING, including the win check. playerHitPulse ignored.
  - Each startOfFrame decrements the flash counter. At 1 -> PLAYING, counter 0.
- Both pulses in the same cycle (PLAYING): alien hit applied first.
  - If that alien hit reaches WIN_HITS -> WON and the player hit is discarded.
  - Otherwise both are applied and the player-hit transition is taken.
- startGame in PLAYING or FLASH: ignored.
- Pulses in IDLE, OVER or WON: ignored.
- hits register: 8 bits, never exceeds WIN_HITS.

## Timing
- All outputs registered. A pulse at cycle N is reflected on outputs at N+1.
- startGame at N: score/lives/hits loaded and playing=1 at N+1.
- Flash duration: exactly FLASH_FRAMES startOfFrame pulses after entry. A startOfFrame in the same cycle as the player hit does not count.
- Reset values: score_bcd=16'h0000, lives=0, state IDLE, playing=0, playerBlink=0, gameOver=0, gameWon=0, flash counter=0, hits=0.
- Asserting resetN mid-game returns immediately to IDLE with reset values. No pending events survive.

## Structure
- Shared package game_pkg: game_state_e enum (IDLE, PLAYING, FLASH, OVER, WON) and the BCD digit typedef (logic [3:0]). Parameter defaults stay in the module.
- Sub-module bcd_score_adder: combinational 4-digit BCD add of a 4-bit constant with saturation to 9999, plus a saturated flag.
- FSM, counters and output registers live in hit_score_manager.

## Test plan
- Reset, then startGame -> next cycle: score_bcd=0000, lives=3, playing=1. Then 12 alienHitPulse (one per frame) -> score_bcd=16'h0012.
- SCORE_PER_HIT=7, score preloaded to 0095 via 95/7 hits plus remainder (or a forced register) -> next hit yields 0102. At 9998, one hit -> 9999; further hits hold 9999.
- playerHitPulse with lives=3 -> lives=2, FLASH. playerBlink toggles every 4 frames. A second playerHitPulse during FLASH is ignored. PLAYING again after exactly 30 startOfFrame pulses.
- Three player hits, each separated by the full flash -> lives=0, gameOver=1, playing=0. Later alien pulses leave score unchanged. startGame -> score 0000, lives 3, PLAYING.
- WIN_HITS=4: the 4th alien hit coincides with playerHitPulse -> gameWon=1, lives unchanged.
- resetN pulsed low during FLASH with score 0042 -> all outputs return to reset values asynchronously; state IDLE.
